// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbiter and sequencer for the single-port data memory behind
// the MEM stage. It shares the memory between the processor's MEM-stage access
// and an external loader/debug port. Accesses have a fixed latency: IDLE, then
// LAT cycles of ACC, then one RESP cycle that carries the ack.
//
// Optional feature macro: DMEM_ARB_STARVE_EN
//   defined   - a 2-bit saturating starvation counter forces an external grant
//               after STARVE_LIMIT consecutive lost arbitrations.
//   undefined - strict CPU priority; the external port wins only when the CPU
//               is not requesting.
module dmem_arbiter #(
  parameter int LAT          = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        StallM,
  output logic        cpu_ack,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ack,
  output logic [31:0] rd_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // The counter only has to reach LAT-1, the index of the last ACC cycle.
  localparam int            CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  // Reject configurations the datapath cannot honour (2-bit starvation count).
  if (LAT < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 3) begin : g_bad_param
    $error("dmem_arbiter: LAT must be >= 1 and STARVE_LIMIT in 1..3");
  end

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;      // 1 = external port owns the access
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ext_ack_q, ext_ack_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          grant_ext;

`ifdef DMEM_ARB_STARVE_EN
  logic [1:0] starve_q, starve_d;
  logic       force_ext;

  assign force_ext = (starve_q == 2'(STARVE_LIMIT));

  // External port wins alone, or when it has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant_ext = ext_req & (~cpu_req | force_ext);
  end

  // Starvation count: bumps on each lost arbitration, clears on grant or idle port.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!ext_req || grant_ext) begin
        starve_d = 2'd0;
      end else if (starve_q != 2'd3) begin
        starve_d = starve_q + 2'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict CPU priority: external port only wins when the CPU is quiet.
  always_comb begin
    grant_ext = ext_req & ~cpu_req;
  end
`endif

  // Next state, access latch and read-data capture; outputs precomputed so
  // that every memory-side output and ack comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ext_req) begin
          state_d = ACC;
          cnt_d   = '0;
          owner_d = grant_ext;
          we_d    = grant_ext ? ext_we    : cpu_we;
          addr_d  = grant_ext ? ext_addr  : cpu_addr;
          wdata_d = grant_ext ? ext_wdata : cpu_wdata;
        end
      end
      ACC: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          if (!we_q) rd_data_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_en_d    = (state_d == ACC);
    mem_we_d    = mem_en_d & we_d;
    mem_addr_d  = mem_en_d ? addr_d  : 32'd0;
    mem_wdata_d = mem_en_d ? wdata_d : 32'd0;
    cpu_ack_d   = (state_d == RESP) & ~owner_d;
    ext_ack_d   = (state_d == RESP) &  owner_d;
  end

  // State, latched access and registered outputs; reset abandons any access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_data_q   <= 32'd0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The pipeline is released in the ack cycle so it advances on its closing edge.
  assign StallM    = cpu_req & ~cpu_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign rd_data   = rd_data_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
